potential_sweep_controller: RTL and testbench
=============================================

POTENTIAL_SWEEP_CONTROLLER -- requirements
Module: potential_sweep_controller

Interface
REQ-001 Parameter NEURONS, default 20, number of neurons whose membrane potential this block owns.
REQ-002 Parameter SETTLE, default 2, cycles adder operands are held before its outputs are sampled; legal range 1..15.
REQ-003 Parameter V_INIT, default 32'h00000000, IEEE-754 single potential loaded into every neuron at reset.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset; synchronous, active-low.
REQ-006 weight_valid  in  1  weight write request.
REQ-007 weight_ready  out  1  weight write accept; high only in IDLE.
REQ-008 weight_id  in  5  target neuron index.
REQ-009 weight_value  in  32  FP32 weight for target neuron.
REQ-010 start_timestep  in  1  one-cycle pulse starting a sweep.
REQ-011 adder_weight  out  32  registered, drives potential adder input_weight.
REQ-012 adder_potential  out  32  registered, drives potential adder decayed_potential.
REQ-013 adder_clear  out  1  registered, drives adder clear.
REQ-014 adder_set  out  1  registered, drives adder set.
REQ-015 adder_final  in  32  adder final_potential.
REQ-016 adder_spike  in  1  adder spike.
REQ-017 spike_valid  out  1  spike event pending.
REQ-018 spike_ready  in  1  downstream accepts spike event.
REQ-019 spike_id  out  5  neuron index of pending spike event.
REQ-020 busy  out  1  high in every state except IDLE.
REQ-021 done  out  1  one-cycle pulse after last neuron of a sweep is written back.

Function
REQ-022 States: INIT, IDLE, LOAD, WAIT, CAPTURE, EMIT, DONE.
REQ-023 INIT lasts exactly 2 cycles: adder_set=1, adder_clear=0; then IDLE with adder_set=0.
REQ-024 IDLE: weight_ready=1; weight_valid&&weight_id<NEURONS writes wbuf[weight_id]=weight_value; repeated writes to one id: last wins; weight_id>=NEURONS accepted and dropped.
REQ-025 IDLE: start_timestep -> LOAD with index=0; start_timestep outside IDLE ignored; weight_valid together with start_timestep: weight written, then sweep starts.
REQ-026 LOAD (1 cycle): adder_weight<=wbuf[index], adder_potential<=decay(pot[index]), settle counter<=0, -> WAIT.
REQ-027 decay(x): exponent x[30:23] decremented by 1 (multiply by 0.5); exponent<=1 yields 32'h00000000; exponent 255 (Inf/NaN) passed unchanged; sign and mantissa otherwise unchanged.
REQ-028 WAIT: counter increments each cycle; after SETTLE cycles -> CAPTURE; operands held constant.
REQ-029 CAPTURE (1 cycle): pot[index]<=adder_final, wbuf[index]<=0; adder_spike=1 -> EMIT; else index==NEURONS-1 -> DONE, else index+1 -> LOAD.
REQ-030 EMIT: spike_valid=1, spike_id=index, held stable until spike_valid&&spike_ready; then same next-state rule as CAPTURE non-spike branch.
REQ-031 DONE: done=1 for one cycle, -> IDLE.
REQ-032 Non-stalled per-neuron latency = SETTLE+2 cycles; full sweep without spikes = NEURONS*(SETTLE+2)+1 cycles from start_timestep to done.
REQ-033 adder_clear=0 in all states except reset; weights written into wbuf are consumed exactly once per sweep.

Reset
REQ-034 rst_n=0 at a clock edge, in any state including mid-sweep or EMIT: state<=INIT, pot[]<=V_INIT, wbuf[]<=0, index<=0, adder_weight/adder_potential<=0, adder_clear<=1, adder_set<=0, spike_valid<=0, done<=0, busy<=1, weight_ready<=0; pending spike event discarded.

Verification
REQ-035 Reset release -> adder_set high exactly 2 cycles, then weight_ready=1, busy=0.
REQ-036 pot[3]=32'h425ED852, wbuf[3]=32'h42470A3D, threshold 32'h4287c7ae -> adder_potential=32'h41DED852, spike_valid with spike_id=3, pot[3] ~9.73 written.
REQ-037 No weights written, start_timestep -> no spike, done exactly NEURONS*(SETTLE+2)+1 cycles later, potentials halved.
REQ-038 spike_ready held low 10 cycles during EMIT -> spike_valid/spike_id stable, sweep stalls, resumes on acceptance.
REQ-039 weight_id=25 and start_timestep during busy -> both ignored; decay of 32'h00800000 -> 32'h00000000.
REQ-040 rst_n low during WAIT of neuron 7 -> INIT next cycle, all potentials V_INIT, no done pulse.

Source files
------------

// File: rtl/potential_sweep_controller.sv
// Sweeps every neuron through an external FP32 potential adder: decays the stored
// potential, adds the buffered weight, writes the result back and reports spikes.
module potential_sweep_controller #(
  parameter int          NEURONS = 20,
  parameter int          SETTLE  = 2,
  parameter logic [31:0] V_INIT  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        weight_valid,
  output logic        weight_ready,
  input  logic [4:0]  weight_id,
  input  logic [31:0] weight_value,
  input  logic        start_timestep,
  output logic [31:0] adder_weight,
  output logic [31:0] adder_potential,
  output logic        adder_clear,
  output logic        adder_set,
  input  logic [31:0] adder_final,
  input  logic        adder_spike,
  output logic        spike_valid,
  input  logic        spike_ready,
  output logic [4:0]  spike_id,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] INIT    = 3'd0;
  localparam logic [2:0] IDLE    = 3'd1;
  localparam logic [2:0] LOAD    = 3'd2;
  localparam logic [2:0] WAIT    = 3'd3;
  localparam logic [2:0] CAPTURE = 3'd4;
  localparam logic [2:0] EMIT    = 3'd5;
  localparam logic [2:0] DONE    = 3'd6;

  localparam logic [5:0] NEURON_CNT  = 6'(NEURONS);
  localparam logic [4:0] LAST_IDX    = 5'(NEURONS - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  logic [2:0]  state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  init_q, init_d;
  logic [31:0] aw_q, aw_d;
  logic [31:0] ap_q, ap_d;
  logic        set_q, set_d;
  logic        clear_q, clear_d;
  logic        wb_we, cap_we;
  logic [31:0] pot_q  [NEURONS];
  logic [31:0] wbuf_q [NEURONS];

  // Halving an FP32 value: subnormal results flush to zero, Inf/NaN pass through.
  function automatic logic [31:0] decay(input logic [31:0] x);
    logic [7:0] e;
    e = x[30:23];
    if (e == 8'hFF)      decay = x;
    else if (e <= 8'd1)  decay = 32'h0000_0000;
    else                 decay = {x[31], e - 8'd1, x[22:0]};
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    init_d  = init_q;
    aw_d    = aw_q;
    ap_d    = ap_q;
    set_d   = set_q;
    clear_d = 1'b0;
    wb_we   = 1'b0;
    cap_we  = 1'b0;
    unique case (state_q)
      INIT: begin
        set_d  = 1'b1;
        init_d = init_q + 2'd1;
        if (init_q == 2'd2) begin
          set_d   = 1'b0;
          state_d = IDLE;
        end
      end
      IDLE: begin
        wb_we = weight_valid && ({1'b0, weight_id} < NEURON_CNT);
        if (start_timestep) begin
          idx_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        aw_d    = wbuf_q[idx_q];
        ap_d    = decay(pot_q[idx_q]);
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == SETTLE_LAST) state_d = CAPTURE;
        else                      cnt_d   = cnt_q + 4'd1;
      end
      CAPTURE, EMIT: begin
        cap_we = (state_q == CAPTURE);
        if (state_q == CAPTURE && adder_spike) begin
          state_d = EMIT;
        end else if (state_q == CAPTURE || spike_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = LOAD;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      state_q <= INIT;
      idx_q   <= '0;
      cnt_q   <= '0;
      init_q  <= '0;
      aw_q    <= '0;
      ap_q    <= '0;
      set_q   <= 1'b0;
      clear_q <= 1'b1;
      // NOTE: both arrays must be reset because a sweep reads every entry, so they map to flops, not RAM.
      for (int i = 0; i < NEURONS; i++) begin
        pot_q[i]  <= V_INIT;
        wbuf_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      init_q  <= init_d;
      aw_q    <= aw_d;
      ap_q    <= ap_d;
      set_q   <= set_d;
      clear_q <= clear_d;
      if (wb_we) wbuf_q[weight_id] <= weight_value;
      // A captured weight is cleared so it is consumed exactly once per sweep.
      if (cap_we) begin
        pot_q[idx_q]  <= adder_final;
        wbuf_q[idx_q] <= '0;
      end
    end
  end

  assign adder_weight    = aw_q;
  assign adder_potential = ap_q;
  assign adder_set       = set_q;
  assign adder_clear     = clear_q;
  assign weight_ready    = (state_q == IDLE);
  assign busy            = (state_q != IDLE);
  assign done            = (state_q == DONE);
  assign spike_valid     = (state_q == EMIT);
  assign spike_id        = idx_q;

endmodule

// File: tb/tb_potential_sweep_controller.sv
// Directed bench for potential_sweep_controller: a neuron-level model predicts each
// sweep, and one negedge monitor compares handshake and adder operands every cycle.
module tb_potential_sweep_controller;

  localparam int          N  = 20;
  localparam int          S  = 2;
  localparam logic [31:0] VI = 32'h3F80_0000;

  logic        clk, rst_n;
  logic        weight_valid, weight_ready, start_timestep;
  logic [4:0]  weight_id, spike_id;
  logic [31:0] weight_value, adder_weight, adder_potential, adder_final;
  logic        adder_clear, adder_set, adder_spike;
  logic        spike_valid, spike_ready, busy, done;
  logic [32:0] adder_r;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] pot_m [N];
  logic [31:0] wbuf_m [N];
  logic [31:0] seen_aw [N];
  logic [31:0] seen_ap [N];

  bit          mon_en, exp_idle, exp_done, exp_spike;
  logic [31:0] exp_aw, exp_ap;
  logic [4:0]  exp_id, last_spike;
  int          done_cyc, n_spikes;

  potential_sweep_controller #(.NEURONS(N), .SETTLE(S), .V_INIT(VI)) dut (
    .clk(clk), .rst_n(rst_n),
    .weight_valid(weight_valid), .weight_ready(weight_ready),
    .weight_id(weight_id), .weight_value(weight_value),
    .start_timestep(start_timestep),
    .adder_weight(adder_weight), .adder_potential(adder_potential),
    .adder_clear(adder_clear), .adder_set(adder_set),
    .adder_final(adder_final), .adder_spike(adder_spike),
    .spike_valid(spike_valid), .spike_ready(spike_ready), .spike_id(spike_id),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in adder: one known spike-and-subtract case, otherwise weight replaces potential.
  function automatic logic [32:0] adder_fn(input logic [31:0] w, input logic [31:0] p);
    if (w == 32'h4247_0A3D && p == 32'h41DE_D852) return {1'b1, 32'h411B_9BB0};
    if (w == 32'h0) return {1'b0, p};
    return {w[0], w};
  endfunction

  assign adder_r     = adder_fn(adder_weight, adder_potential);
  assign adder_spike = adder_r[32];
  assign adder_final = adder_r[31:0];

  function automatic logic [31:0] decay_m(input logic [31:0] x);
    int e;
    e = int'(x[30:23]);
    if (e == 255) return x;
    if (e <= 1)   return 32'h0;
    return x - 32'h0080_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("busy", 32'(busy), 32'(!exp_idle));
      check("weight_ready", 32'(weight_ready), 32'(exp_idle));
      check("adder_clear", 32'(adder_clear), 32'h0);
      check("adder_set", 32'(adder_set), 32'h0);
      check("done", 32'(done), 32'(exp_done));
      check("spike_valid", 32'(spike_valid), 32'(exp_spike));
      if (exp_spike) check("spike_id", 32'(spike_id), 32'(exp_id));
      check("adder_weight", adder_weight, exp_aw);
      check("adder_potential", adder_potential, exp_ap);
      if (done) done_cyc = cyc;
      if (spike_valid) last_spike = spike_id;
    end
  end

  task automatic write_w(input logic [4:0] id, input logic [31:0] v);
    weight_valid = 1'b1;
    weight_id    = id;
    weight_value = v;
    if (int'(id) < N) wbuf_m[id] = v;
    @(posedge clk); #1;
    weight_valid = 1'b0;
  endtask

  task automatic run_sweep(input int stall, input bit inject, input bit ww,
                           input logic [4:0] wid, input logic [31:0] wval);
    int          start_cyc, extra;
    logic [31:0] ew, ep;
    logic [32:0] r;
    extra    = 0;
    n_spikes = 0;
    done_cyc = -1;
    start_timestep = 1'b1;
    start_cyc      = cyc;
    if (ww) begin
      weight_valid = 1'b1;
      weight_id    = wid;
      weight_value = wval;
      if (int'(wid) < N) wbuf_m[wid] = wval;
    end
    @(posedge clk); #1;
    start_timestep = 1'b0;
    weight_valid   = 1'b0;
    exp_idle       = 1'b0;
    for (int i = 0; i < N; i++) begin
      ew = wbuf_m[i];
      ep = decay_m(pot_m[i]);
      r  = adder_fn(ew, ep);
      if (inject && i == 2) begin
        weight_valid   = 1'b1;
        weight_id      = 5'd5;
        weight_value   = 32'h5555_5555;
        start_timestep = 1'b1;
      end
      @(posedge clk); #1;
      exp_aw     = ew;
      exp_ap     = ep;
      seen_aw[i] = adder_weight;
      seen_ap[i] = adder_potential;
      if (inject && i == 2) begin
        weight_id      = 5'd25;
        start_timestep = 1'b0;
      end
      repeat (S) begin @(posedge clk); #1; end
      weight_valid = 1'b0;
      pot_m[i]  = r[31:0];
      wbuf_m[i] = 32'h0;
      @(posedge clk); #1;
      if (r[32]) begin
        n_spikes++;
        extra    += stall + 1;
        exp_spike = 1'b1;
        exp_id    = 5'(i);
        repeat (stall) begin @(posedge clk); #1; end
        spike_ready = 1'b1;
        @(posedge clk); #1;
        spike_ready = 1'b0;
        exp_spike   = 1'b0;
      end
    end
    exp_done = 1'b1;
    @(posedge clk); #1;
    exp_done = 1'b0;
    exp_idle = 1'b1;
    check("done_latency", 32'(done_cyc - start_cyc), 32'(N * (S + 2) + 1 + extra));
  endtask

  task automatic reset_model();
    for (int i = 0; i < N; i++) begin
      pot_m[i]  = VI;
      wbuf_m[i] = 32'h0;
    end
    exp_aw    = 32'h0;
    exp_ap    = 32'h0;
    exp_idle  = 1'b1;
    exp_done  = 1'b0;
    exp_spike = 1'b0;
  endtask

  initial begin
    int set_cnt, done_bad;
    rst_n = 1'b0; weight_valid = 1'b0; weight_id = '0; weight_value = '0;
    start_timestep = 1'b0; spike_ready = 1'b0; mon_en = 1'b0;
    reset_model();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_clear", 32'(adder_clear), 32'h1);
    check("rst_set", 32'(adder_set), 32'h0);
    check("rst_busy", 32'(busy), 32'h1);
    check("rst_ready", 32'(weight_ready), 32'h0);
    check("rst_spike_valid", 32'(spike_valid), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_aw", adder_weight, 32'h0);
    check("rst_ap", adder_potential, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    set_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (adder_set) set_cnt++;
      else if (set_cnt > 0) break;
    end
    check("init_set_cycles", 32'(set_cnt), 32'd2);
    check("init_ready", 32'(weight_ready), 32'h1);
    check("init_busy", 32'(busy), 32'h0);
    check("init_clear", 32'(adder_clear), 32'h0);
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Sweep A: no weights, potentials only halve.
    run_sweep(0, 1'b0, 1'b0, 5'd0, 32'h0);
    check("A_spikes", 32'(n_spikes), 32'd0);
    check("A_ap0", seen_ap[0], 32'h3F00_0000);
    check("A_ap3", seen_ap[3], 32'h3F00_0000);

    // Sweep B: loaded weights, dropped id, last-wins, weight with start, stalled spike, busy stray inputs.
    write_w(5'd3,  32'h425E_D852);
    write_w(5'd7,  32'h0100_0000);
    write_w(5'd8,  32'h0080_0000);
    write_w(5'd9,  32'h7F80_0000);
    write_w(5'd25, 32'hDEAD_BEEF);
    write_w(5'd10, 32'h1234_5671);
    write_w(5'd10, 32'h4000_0000);
    write_w(5'd12, 32'h4040_0001);
    run_sweep(10, 1'b1, 1'b1, 5'd14, 32'h4100_0000);
    check("B_spikes", 32'(n_spikes), 32'd1);
    check("B_spike_id", 32'(last_spike), 32'd12);
    check("B_aw10_last_wins", seen_aw[10], 32'h4000_0000);
    check("B_aw14_with_start", seen_aw[14], 32'h4100_0000);
    check("B_ap3", seen_ap[3], 32'h3E80_0000);

    // Sweep C: reference spike on neuron 3 plus decay boundaries.
    write_w(5'd3, 32'h4247_0A3D);
    run_sweep(0, 1'b0, 1'b0, 5'd0, 32'h0);
    check("C_ap3", seen_ap[3], 32'h41DE_D852);
    check("C_spike_id", 32'(last_spike), 32'd3);
    check("C_spikes", 32'(n_spikes), 32'd1);
    check("C_ap7_exp2", seen_ap[7], 32'h0080_0000);
    check("C_ap8_exp1", seen_ap[8], 32'h0000_0000);
    check("C_ap9_inf", seen_ap[9], 32'h7F80_0000);
    check("C_aw5_busy_write", seen_aw[5], 32'h0);
    check("C_aw10_consumed", seen_aw[10], 32'h0);

    // Sweep D: written-back post-spike potential reappears halved.
    run_sweep(0, 1'b0, 1'b0, 5'd0, 32'h0);
    check("D_ap3", seen_ap[3], 32'h409B_9BB0);
    check("D_spikes", 32'(n_spikes), 32'd0);

    // Reset during WAIT of neuron 7.
    write_w(5'd15, 32'h40A0_0000);
    mon_en = 1'b0;
    start_timestep = 1'b1;
    @(posedge clk); #1;
    start_timestep = 1'b0;
    repeat (7 * (S + 2) + 1) begin @(posedge clk); #1; end
    check("abort_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy_init", 32'(busy), 32'h1);
    check("abort_ready", 32'(weight_ready), 32'h0);
    check("abort_clear", 32'(adder_clear), 32'h1);
    check("abort_done", 32'(done), 32'h0);
    check("abort_aw", adder_weight, 32'h0);
    check("abort_ap", adder_potential, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    done_bad = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) done_bad++;
      if (weight_ready) break;
    end
    check("abort_no_done", 32'(done_bad), 32'h0);
    check("abort_back_idle", 32'(weight_ready), 32'h1);
    reset_model();
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Sweep E: everything back at V_INIT, pre-reset weight gone.
    run_sweep(0, 1'b0, 1'b0, 5'd0, 32'h0);
    check("E_aw15_cleared", seen_aw[15], 32'h0);
    check("E_ap7", seen_ap[7], 32'h3F00_0000);
    check("E_ap19", seen_ap[19], 32'h3F00_0000);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
